axis_switch_simple_1x2: RTL and testbench

AXIS_SWITCH_SIMPLE_1X2 -- requirements
Module: axis_switch_simple_1x2

---
 rtl/axis_switch_simple_1x2.sv | 162 ++++++++++++++++
 tb/tb_axis_switch_simple_1x2.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_switch_simple_1x2.sv
// One-input, two-output AXI-Stream packet router with per-output enables.
// Disabled-target packets are swallowed and counted in a saturating drop counter.
module axis_switch_simple_1x2 #(
  parameter int DATAW = 24,
  parameter int DROPW = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               m0_en,
  input  logic               m1_en,
  input  logic [DATAW-1:0]   s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tuser,
  input  logic               s_axis_tlast,
  input  logic [DATAW/8-1:0] s_axis_tstrb,
  input  logic [DATAW/8-1:0] s_axis_tkeep,
  input  logic               s_axis_tid,
  input  logic               s_axis_tdest,
  output logic [DATAW-1:0]   m0_axis_tdata,
  output logic               m0_axis_tvalid,
  input  logic               m0_axis_tready,
  output logic               m0_axis_tuser,
  output logic               m0_axis_tlast,
  output logic [DATAW/8-1:0] m0_axis_tstrb,
  output logic [DATAW/8-1:0] m0_axis_tkeep,
  output logic               m0_axis_tid,
  output logic               m0_axis_tdest,
  output logic [DATAW-1:0]   m1_axis_tdata,
  output logic               m1_axis_tvalid,
  input  logic               m1_axis_tready,
  output logic               m1_axis_tuser,
  output logic               m1_axis_tlast,
  output logic [DATAW/8-1:0] m1_axis_tstrb,
  output logic [DATAW/8-1:0] m1_axis_tkeep,
  output logic               m1_axis_tid,
  output logic               m1_axis_tdest,
  output logic [DROPW-1:0]   drop_cnt
);

  // state  | meaning
  // IDLE   | between packets; route chosen from the current beat's tdest
  // ROUTE0 | mid-packet, beats locked to m0
  // ROUTE1 | mid-packet, beats locked to m1
  // DROP   | mid-packet, beats consumed and discarded
  typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1, DROP} state_t;

  state_t state, state_nxt;
  logic   route_en;
  logic   dest_sel;
  logic   drop_sel;
  logic   s_hs;
  logic   load0;
  logic   load1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    route_en = s_axis_tdest ? m1_en : m0_en;
    dest_sel = 1'b0;
    drop_sel = 1'b0;
    case (state)
      IDLE: begin
        dest_sel = s_axis_tdest;
        drop_sel = ~route_en;
      end
      ROUTE0: dest_sel = 1'b0;
      ROUTE1: dest_sel = 1'b1;
      DROP:   drop_sel = 1'b1;
      default: begin
        dest_sel = 1'b0;
        drop_sel = 1'b0;
      end
    endcase
  end

  // Ready only looks at the selected output so a stalled idle port never blocks.
  assign s_axis_tready = ~areset & (drop_sel |
                         (dest_sel ? (~m1_axis_tvalid | m1_axis_tready)
                                   : (~m0_axis_tvalid | m0_axis_tready)));
  assign s_hs  = s_axis_tvalid & s_axis_tready;
  assign load0 = s_hs & ~drop_sel & ~dest_sel;
  assign load1 = s_hs & ~drop_sel &  dest_sel;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s_hs && !s_axis_tlast) begin
          if (drop_sel)      state_nxt = DROP;
          else if (dest_sel) state_nxt = ROUTE1;
          else               state_nxt = ROUTE0;
        end
      end
      ROUTE0, ROUTE1, DROP: begin
        if (s_hs && s_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m0_axis_tvalid <= 1'b0;
      m0_axis_tdata  <= '0;
      m0_axis_tuser  <= 1'b0;
      m0_axis_tlast  <= 1'b0;
      m0_axis_tstrb  <= '0;
      m0_axis_tkeep  <= '0;
      m0_axis_tid    <= 1'b0;
      m0_axis_tdest  <= 1'b0;
    end else if (load0) begin
      m0_axis_tvalid <= 1'b1;
      m0_axis_tdata  <= s_axis_tdata;
      m0_axis_tuser  <= s_axis_tuser;
      m0_axis_tlast  <= s_axis_tlast;
      m0_axis_tstrb  <= s_axis_tstrb;
      m0_axis_tkeep  <= s_axis_tkeep;
      m0_axis_tid    <= s_axis_tid;
      m0_axis_tdest  <= s_axis_tdest;
    end else if (m0_axis_tready) begin
      m0_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m1_axis_tvalid <= 1'b0;
      m1_axis_tdata  <= '0;
      m1_axis_tuser  <= 1'b0;
      m1_axis_tlast  <= 1'b0;
      m1_axis_tstrb  <= '0;
      m1_axis_tkeep  <= '0;
      m1_axis_tid    <= 1'b0;
      m1_axis_tdest  <= 1'b0;
    end else if (load1) begin
      m1_axis_tvalid <= 1'b1;
      m1_axis_tdata  <= s_axis_tdata;
      m1_axis_tuser  <= s_axis_tuser;
      m1_axis_tlast  <= s_axis_tlast;
      m1_axis_tstrb  <= s_axis_tstrb;
      m1_axis_tkeep  <= s_axis_tkeep;
      m1_axis_tid    <= s_axis_tid;
      m1_axis_tdest  <= s_axis_tdest;
    end else if (m1_axis_tready) begin
      m1_axis_tvalid <= 1'b0;
    end
  end

  // A dropped packet counts once, on its tlast beat, including single-beat drops from IDLE.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      drop_cnt <= '0;
    end else if (s_hs && drop_sel && s_axis_tlast && (drop_cnt != {DROPW{1'b1}})) begin
      drop_cnt <= drop_cnt + DROPW'(1);
    end
  end

endmodule

// File: tb/tb_axis_switch_simple_1x2.sv
// Randomized and directed bench for axis_switch_simple_1x2 against a queue-based
// packet model: each output is a FIFO of expected beats, drops are a saturating tally.
module tb_axis_switch_simple_1x2;
  localparam int DATAW = 24;
  localparam int DROPW = 2;
  localparam int KW    = DATAW / 8;
  localparam int BW    = DATAW + 2 * KW + 4;
  localparam int DMAX  = (1 << DROPW) - 1;

  logic aclk = 1'b0;
  logic areset;
  logic m0_en, m1_en;
  logic [DATAW-1:0] s_tdata;
  logic s_tvalid, s_tready, s_tuser, s_tlast, s_tid, s_tdest;
  logic [KW-1:0] s_tstrb, s_tkeep;
  logic [DATAW-1:0] m0_tdata, m1_tdata;
  logic m0_tvalid, m0_tready, m0_tuser, m0_tlast, m0_tid, m0_tdest;
  logic m1_tvalid, m1_tready, m1_tuser, m1_tlast, m1_tid, m1_tdest;
  logic [KW-1:0] m0_tstrb, m0_tkeep, m1_tstrb, m1_tkeep;
  logic [DROPW-1:0] drop_cnt;

  always #5 aclk = ~aclk;

  axis_switch_simple_1x2 #(.DATAW(DATAW), .DROPW(DROPW)) dut (
    .aclk(aclk), .areset(areset), .m0_en(m0_en), .m1_en(m1_en),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tstrb(s_tstrb),
    .s_axis_tkeep(s_tkeep), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .m0_axis_tdata(m0_tdata), .m0_axis_tvalid(m0_tvalid), .m0_axis_tready(m0_tready),
    .m0_axis_tuser(m0_tuser), .m0_axis_tlast(m0_tlast), .m0_axis_tstrb(m0_tstrb),
    .m0_axis_tkeep(m0_tkeep), .m0_axis_tid(m0_tid), .m0_axis_tdest(m0_tdest),
    .m1_axis_tdata(m1_tdata), .m1_axis_tvalid(m1_tvalid), .m1_axis_tready(m1_tready),
    .m1_axis_tuser(m1_tuser), .m1_axis_tlast(m1_tlast), .m1_axis_tstrb(m1_tstrb),
    .m1_axis_tkeep(m1_tkeep), .m1_axis_tid(m1_tid), .m1_axis_tdest(m1_tdest),
    .drop_cnt(drop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  bit in_pkt;
  int cur_dest;
  int drops;
  bit last_acc;
  bit rand_rdy;

  wire [BW-1:0] s_beat  = {s_tdata, s_tuser, s_tlast, s_tstrb, s_tkeep, s_tid, s_tdest};
  wire [BW-1:0] m0_beat = {m0_tdata, m0_tuser, m0_tlast, m0_tstrb, m0_tkeep, m0_tid, m0_tdest};
  wire [BW-1:0] m1_beat = {m1_tdata, m1_tuser, m1_tlast, m1_tstrb, m1_tkeep, m1_tid, m1_tdest};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0/1 = output port, 2 = discard
  function automatic int pick_dest();
    if (in_pkt) return cur_dest;
    return (s_tdest ? m1_en : m0_en) ? int'(s_tdest) : 2;
  endfunction

  function automatic bit exp_rdy();
    int d;
    if (areset) return 1'b0;
    d = pick_dest();
    if (d == 2) return 1'b1;
    if (d == 0) return (q0.size() == 0) || m0_tready;
    return (q1.size() == 0) || m1_tready;
  endfunction

  task automatic check_outputs();
    if (areset) begin
      chk("rst_s_tready", 64'(s_tready), 64'(0));
      chk("rst_m0_tvalid", 64'(m0_tvalid), 64'(0));
      chk("rst_m1_tvalid", 64'(m1_tvalid), 64'(0));
      chk("rst_m0_beat", 64'(m0_beat), 64'(0));
      chk("rst_m1_beat", 64'(m1_beat), 64'(0));
      chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    end else begin
      chk("s_tready", 64'(s_tready), 64'(exp_rdy()));
      chk("m0_tvalid", 64'(m0_tvalid), 64'(q0.size() != 0));
      chk("m1_tvalid", 64'(m1_tvalid), 64'(q1.size() != 0));
      if (q0.size() != 0) chk("m0_beat", 64'(m0_beat), 64'(q0[0]));
      if (q1.size() != 0) chk("m1_beat", 64'(m1_beat), 64'(q1[0]));
      chk("drop_cnt", 64'(drop_cnt), 64'(drops));
    end
  endtask

  // Starts and ends at posedge+1; checks at negedge, updates the model at posedge.
  task automatic cycle();
    bit acc, p0, p1, lst;
    int d;
    logic [BW-1:0] b;
    if (rand_rdy) begin
      m0_tready = 1'($urandom_range(0, 1));
      m1_tready = 1'($urandom_range(0, 1));
    end
    @(negedge aclk);
    check_outputs();
    acc = s_tvalid && exp_rdy();
    p0  = (q0.size() != 0) && m0_tready;
    p1  = (q1.size() != 0) && m1_tready;
    b   = s_beat;
    lst = s_tlast;
    d   = pick_dest();
    @(posedge aclk);
    if (areset) begin
      q0.delete();
      q1.delete();
      in_pkt = 1'b0;
      drops  = 0;
      acc    = 1'b0;
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (d == 0)      q0.push_back(b);
        else if (d == 1) q1.push_back(b);
        else if (lst && drops < DMAX) drops++;
        in_pkt   = !lst;
        cur_dest = d;
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic set_beat(input logic [DATAW-1:0] data, input bit last, input bit dest);
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    s_tdest  = dest;
    s_tuser  = 1'($urandom_range(0, 1));
    s_tstrb  = KW'($urandom);
    s_tkeep  = KW'($urandom);
    s_tid    = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [DATAW-1:0] data, input bit last, input bit dest,
                           output int waited);
    set_beat(data, last, dest);
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (!last_acc && waited < 200);
    if (!last_acc) chk("accept_timeout", 64'(last_acc), 64'(1));
  endtask

  task automatic drain();
    int n;
    s_tvalid = 1'b0;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      if (!rand_rdy) begin
        m0_tready = 1'b1;
        m1_tready = 1'b1;
      end
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(q0.size() + q1.size()), 64'(0));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cycle();
    cycle();
    areset = 1'b0;
  endtask

  initial begin
    int w;
    logic [DATAW-1:0] held;
    areset = 1'b1;
    m0_en = 1'b1; m1_en = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
    s_tstrb = '0; s_tkeep = '0; s_tid = 1'b0; s_tdest = 1'b0;
    m0_tready = 1'b1; m1_tready = 1'b1;
    in_pkt = 1'b0; cur_dest = 0; drops = 0; last_acc = 1'b0; rand_rdy = 1'b0;
    do_reset();

    // routed 3-beat packet, one-cycle latency
    send_beat(24'h111111, 1'b0, 1'b0, w);
    chk("t26_latency", 64'(m0_tdata), 64'h111111);
    send_beat(24'h222222, 1'b0, 1'b0, w);
    send_beat(24'h333333, 1'b1, 1'b0, w);
    chk("t26_last", 64'({m0_tvalid, m0_tlast, m0_tdata}), 64'({2'b11, 24'h333333}));
    drain();

    // backpressure on m1
    m1_tready = 1'b0;
    send_beat(24'hA0A0A0, 1'b0, 1'b1, w);
    held = m1_tdata;
    set_beat(24'hB1B1B1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t27_stall", 64'(last_acc), 64'(0));
      chk("t27_hold", 64'(m1_tdata), 64'(held));
    end
    m1_tready = 1'b1;
    send_beat(24'hB1B1B1, 1'b1, 1'b1, w);
    drain();

    // drop 4 beats
    m0_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(DATAW'(i + 5), i == 3, 1'b0, w);
      chk("t28_ready", 64'(w), 64'(1));
    end
    drain();
    chk("t28_drop_cnt", 64'(drop_cnt), 64'(1));

    // mid-packet enable/tdest changes are ignored
    m0_en = 1'b1; m1_en = 1'b1;
    send_beat(24'hC0C0C0, 1'b0, 1'b1, w);
    m1_en = 1'b0;
    send_beat(24'hC1C1C1, 1'b0, 1'b0, w);
    send_beat(24'hC2C2C2, 1'b1, 1'b0, w);
    chk("t29_m1", 64'({m1_tvalid, m1_tdata}), 64'({1'b1, 24'hC2C2C2}));
    send_beat(24'hC3C3C3, 1'b1, 1'b1, w);
    drain();
    chk("t29_new_drop", 64'(drop_cnt), 64'(2));
    m1_en = 1'b1;

    // async reset mid-packet
    send_beat(24'hD0D0D0, 1'b0, 1'b0, w);
    set_beat(24'hD1D1D1, 1'b0, 1'b0);
    areset = 1'b1;
    #1;
    chk("t30_async_m0", 64'(m0_tvalid), 64'(0));
    chk("t30_async_rdy", 64'(s_tready), 64'(0));
    cycle();
    areset = 1'b0;
    send_beat(24'hE0E0E0, 1'b1, 1'b1, w);
    chk("t30_m1", 64'({m1_tvalid, m0_tvalid, m1_tdata}), 64'({2'b10, 24'hE0E0E0}));
    drain();

    // next packet to a different, free output goes through while m0 is stalled
    m0_tready = 1'b0;
    send_beat(24'hF0F0F0, 1'b1, 1'b0, w);
    send_beat(24'hF1F1F1, 1'b1, 1'b1, w);
    chk("t19_b2b", 64'(w), 64'(1));
    drain();

    // full throughput alternating outputs
    for (int i = 0; i < 8; i++) begin
      send_beat(DATAW'($urandom), 1'b1, i[0], w);
      chk("t31_rate", 64'(w), 64'(1));
    end
    drain();

    // counter saturation
    do_reset();
    m0_en = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(DATAW'(i), 1'b1, 1'b0, w);
    s_tvalid = 1'b0;
    cycle();
    chk("t31_sat", 64'(drop_cnt), 64'(3));

    // randomized traffic
    do_reset();
    rand_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(1, 5);
      m0_en = 1'($urandom_range(0, 3) != 0);
      m1_en = 1'($urandom_range(0, 3) != 0);
      for (int b = 0; b < len; b++) begin
        if (b != 0 && $urandom_range(0, 2) == 0) begin
          m0_en = 1'($urandom_range(0, 1));
          m1_en = 1'($urandom_range(0, 1));
        end
        send_beat(DATAW'($urandom), b == len - 1, 1'($urandom_range(0, 1)), w);
        if ($urandom_range(0, 3) == 0) begin
          s_tvalid = 1'b0;
          cycle();
        end
      end
    end
    rand_rdy = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
